// File: rtl/moving_average_engine.sv
// Rolling-window mean of unsigned samples: circular buffer plus running sum,
// one accepted sample per four cycles, result registered after a divide step.
module moving_average_engine #(
    parameter int unsigned WINDOW = 20,
    parameter int unsigned DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] new_price,
    input  logic          clear,
    output logic          in_ready,
    output logic [31:0]   moving_avg,
    output logic [31:0]   window_sum,
    output logic [15:0]   sample_count,
    output logic          full,
    output logic          done
);

    localparam int unsigned SW = $clog2(WINDOW) + DW;
    localparam int unsigned SX = SW + 1;
    localparam int unsigned CW = $clog2(WINDOW + 1);
    localparam int unsigned PW = $clog2(WINDOW);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIV,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_n;
    logic [DW-1:0]   sample_q;
    logic [SW-1:0]   sum_q;
    logic [SW-1:0]   sum_next;
    logic [SW-1:0]   quot;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_next;
    logic [31:0]     avg_q;
    logic [31:0]     wsum_q;
    logic [DW-1:0]   buf_mem [WINDOW];

    assign in_ready     = (state_q == IDLE) && !clear;
    assign full         = (count_q == CW'(WINDOW));
    assign done         = (state_q == DONE);
    assign sample_count = 16'(count_q);
    assign moving_avg   = avg_q;
    assign window_sum   = wsum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready) state_n = ACCUM;
            ACCUM:   state_n = DIV;
            DIV:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // One extra bit absorbs sum+sample before the evicted sample is removed.
    always_comb begin
        sum_next    = SW'({1'b0, sum_q} + SX'(sample_q)
                          - (full ? SX'(buf_mem[wr_ptr_q]) : SX'(0)));
        wr_ptr_next = (wr_ptr_q == PW'(WINDOW - 1)) ? '0 : wr_ptr_q + PW'(1);
        quot        = sum_q / SW'(count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            sum_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            avg_q    <= '0;
            wsum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        sum_q    <= '0;
                        count_q  <= '0;
                        wr_ptr_q <= '0;
                    end else if (in_valid) begin
                        sample_q <= new_price;
                    end
                end
                ACCUM: begin
                    sum_q    <= sum_next;
                    wr_ptr_q <= wr_ptr_next;
                    if (!full) count_q <= count_q + CW'(1);
                end
                DIV: begin
                    avg_q  <= 32'(quot);
                    wsum_q <= 32'(sum_q);
                end
                default: ;
            endcase
        end
    end

    // Buffer needs no reset: count_q decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (state_q == ACCUM) buf_mem[wr_ptr_q] <= sample_q;
    end

endmodule
